// File: rtl/fft_pkg.sv
// Shared definitions for the FFT sample-buffer read side.
// Holds the default sizes, the FSM state type and a bit-reversal helper.
package fft_pkg;

    localparam int LOG2N_DEF      = 8;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int LOG2N_MAX      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [LOG2N_MAX-1:0] bitrev(input logic [LOG2N_MAX-1:0] v, input int w);
        logic [LOG2N_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N_MAX; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_counter.sv
// Enable-driven wrap-around counter; o_max flags the terminal count.
module fft_counter #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_max
);

    assign o_max = (o_count == MAX);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_count <= '0;
        end else if (i_en) begin
            o_count <= o_max ? '0 : o_count + 1'b1;
        end
    end

endmodule

// File: rtl/fft_skid_fifo2.sv
// Two-entry valid/ready FIFO; the head entry drives the output directly.
module fft_skid_fifo2 #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_occ
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       occ_q;
    logic             pop;

    assign o_valid = (occ_q != 2'd0);
    assign o_data  = head_q;
    assign o_occ   = occ_q;
    assign pop     = o_valid && i_ready;

    // NOTE: the two storage entries are reset as well, because o_data must read zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            case ({i_push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) head_q <= i_data;
                    else               tail_q <= i_data;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_q <= i_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fft_bitrev_reader.sv
// Reads one N-word frame from a synchronous BRAM in bit-reversed (or natural)
// order and streams it out on valid/ready with full backpressure.
module fft_bitrev_reader
    import fft_pkg::*;
#(
    parameter int LOG2N       = LOG2N_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter bit BIT_REVERSE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_rd_en,
    output logic [LOG2N-1:0]      o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last
);

    localparam logic [LOG2N-1:0] CNT_MAX = {LOG2N{1'b1}};

    state_t              state_q, state_d;
    logic [LOG2N-1:0]    cnt;
    logic                cnt_max;
    logic                inflight_q;
    logic                last_q;
    logic                done_q;
    logic [1:0]          occ;
    logic                pop;
    logic                issue;
    logic [DATA_WIDTH:0] head;

    assign pop = o_valid && i_ready;

    // Never have more words owed to the FIFO than it can hold after this cycle's pop.
    assign issue = (state_q == READ) &&
                   (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    fft_counter #(
        .WIDTH (LOG2N),
        .MAX   (CNT_MAX)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (issue),
        .o_count (cnt),
        .o_max   (cnt_max)
    );

    assign o_rd_en   = issue;
    assign o_rd_addr = BIT_REVERSE ? LOG2N'(bitrev(LOG2N_MAX'(cnt), LOG2N)) : cnt;
    assign o_busy    = (state_q != IDLE);
    assign o_done    = done_q;

    // NOTE: next-state is assigned a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start)          state_d = READ;
            READ:    if (issue && cnt_max) state_d = DRAIN;
            DRAIN:   if (pop && o_last)    state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            last_q     <= issue && cnt_max;
            done_q     <= (state_q == DRAIN) && pop && o_last;
        end
    end

    // The last tag rides alongside its data word through the FIFO.
    fft_skid_fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (inflight_q),
        .i_data  ({last_q, i_rd_data}),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_data  (head),
        .o_occ   (occ)
    );

    assign o_last = head[DATA_WIDTH];
    assign o_data = head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_fft_bitrev_reader.sv
// Bench for fft_bitrev_reader: an N=8 bit-reversed instance and an N=256 natural-order instance.
module tb_fft_bitrev_reader;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, ready, sel;

    logic          busy_a, done_a, rd_en_a, valid_a, last_a;
    logic [2:0]    addr_a;
    logic [DW-1:0] rd_data_a, data_a;
    logic          busy_b, done_b, rd_en_b, valid_b, last_b;
    logic [7:0]    addr_b;
    logic [DW-1:0] rd_data_b, data_b;

    logic [DW-1:0] ram_a [8];
    logic [DW-1:0] ram_b [256];

    fft_bitrev_reader #(.LOG2N(3), .DATA_WIDTH(DW), .BIT_REVERSE(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .i_start(start && !sel), .o_busy(busy_a), .o_done(done_a),
        .o_rd_en(rd_en_a), .o_rd_addr(addr_a), .i_rd_data(rd_data_a),
        .o_valid(valid_a), .i_ready(ready), .o_data(data_a), .o_last(last_a)
    );

    fft_bitrev_reader #(.LOG2N(8), .DATA_WIDTH(DW), .BIT_REVERSE(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .i_start(start && sel), .o_busy(busy_b), .o_done(done_b),
        .o_rd_en(rd_en_b), .o_rd_addr(addr_b), .i_rd_data(rd_data_b),
        .o_valid(valid_b), .i_ready(ready), .o_data(data_b), .o_last(last_b)
    );

    // Synchronous-read BRAM models: data one cycle after the enable.
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= ram_a[addr_a];
        if (rd_en_b) rd_data_b <= ram_b[addr_b];
    end

    logic          m_busy, m_done, m_rd_en, m_valid, m_last;
    logic [DW-1:0] m_data;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_rd_en = sel ? rd_en_b : rd_en_a;
    assign m_valid = sel ? valid_b : valid_a;
    assign m_last  = sel ? last_b  : last_a;
    assign m_data  = sel ? data_b  : data_a;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int tb_bitrev(input int k, input int bits);
        int r = 0;
        int x = k;
        for (int i = 0; i < bits; i++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } word_t;
    word_t exp_q[$];

    typedef struct {
        logic          start;
        logic          ready;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic          exp_last;
        logic          exp_done;
        logic          exp_busy;
        logic          exp_rd_en;
        logic [2:0]    exp_addr;
    } vec_t;
    vec_t tbl[14];
    int   order8[8];

    task automatic drive(input logic st, input logic rdy);
        @(negedge clk);
        start = st;
        ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // mode: 0 ready high, 1 ready toggling 1,0,.., 2 random, 3 stalled for 20 cycles.
    // abort_at >= 0 asserts rst once that many words have been transferred.
    task automatic run_frame(input bit use_b, input int mode, input bit restart_mid, input int abort_at);
        int            n, bits, issued, hs, first_hs, done_cyc, a;
        bit            br;
        logic          pv, pr, rdy, st;
        logic [DW-1:0] pd;
        word_t         w;
        sel  = use_b;
        n    = use_b ? 256 : 8;
        bits = use_b ? 8 : 3;
        br   = !use_b;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            a = br ? tb_bitrev(k, bits) : k;
            w.data = use_b ? ram_b[a] : ram_a[a];
            w.last = (k == n - 1);
            exp_q.push_back(w);
        end
        check("idle_before_start", m_busy, 1'b0);
        issued = 0; hs = 0; first_hs = -1; done_cyc = -1;
        pv = 1'b0; pr = 1'b0; pd = '0;
        for (int cyc = 0; cyc < 4 * n + 40; cyc++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                2:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc >= 20);
            endcase
            st = (cyc == 0) || (restart_mid && (cyc == 5 || cyc == 9));
            if (abort_at >= 0 && cyc > 0 && hs == abort_at) begin
                @(negedge clk);
                rst   = 1'b1;
                start = 1'b0;
                ready = 1'b1;
                #1;
                return;
            end
            drive(st, rdy);
            if (m_rd_en) issued++;
            if (pv && !pr) begin
                check("stall_valid_hold", m_valid, 1'b1);
                check("stall_data_hold", m_data, pd);
            end
            if (m_valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 1'b1, 1'b0);
                end else begin
                    w = exp_q.pop_front();
                    check($sformatf("data_idx%0d", hs), m_data, w.data);
                    check($sformatf("last_idx%0d", hs), m_last, w.last);
                end
                hs++;
                if (first_hs < 0) first_hs = cyc;
            end
            check("outstanding_le2", 64'(issued - hs <= 2), 64'd1);
            if (mode == 3 && cyc == 19) begin
                check("stall_reads_issued", issued, 2);
                check("stall_head_valid", m_valid, 1'b1);
                check("stall_head_data", m_data, exp_q[0].data);
            end
            if (m_done) begin
                done_cyc = cyc;
                check("done_word_count", hs, n);
                check("done_busy_low", m_busy, 1'b0);
                check("done_valid_low", m_valid, 1'b0);
                break;
            end
            pv = m_valid;
            pr = ready;
            pd = m_data;
        end
        if (done_cyc < 0) check("done_timeout", 1'b0, 1'b1);
        if (mode == 0) begin
            check("first_word_latency", first_hs, 3);
            check("frame_length", done_cyc, n + 3);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1);
            check("post_no_done", m_done, 1'b0);
            check("post_busy_low", m_busy, 1'b0);
            check("post_valid_low", m_valid, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b0; sel = 1'b0;
        for (int i = 0; i < 8; i++) ram_a[i] = DW'(i);
        for (int i = 0; i < 256; i++) ram_b[i] = ~DW'(i);
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",  {busy_a, busy_b}, 2'b00);
        check("rst_done",  {done_a, done_b}, 2'b00);
        check("rst_rd_en", {rd_en_a, rd_en_b}, 2'b00);
        check("rst_valid", {valid_a, valid_b}, 2'b00);
        check("rst_last",  {last_a, last_b}, 2'b00);
        check("rst_addr",  {addr_a, addr_b}, 11'd0);
        check("rst_data",  {data_a, data_b}, 64'd0);
        rst = 1'b0;

        // Cycle-exact N=8 frame, RAM[a]=a, then a start in the o_done cycle.
        order8 = '{0, 4, 2, 6, 1, 5, 3, 7};
        for (int i = 0; i < 14; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[0].start    = 1'b1;
        tbl[0].exp_busy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tbl[1+k].exp_rd_en = 1'b1;
            tbl[1+k].exp_addr  = 3'(order8[k]);
            tbl[3+k].exp_valid = 1'b1;
            tbl[3+k].exp_data  = DW'(order8[k]);
            tbl[3+k].exp_last  = (k == 7);
        end
        tbl[11].start    = 1'b1;
        tbl[11].exp_busy = 1'b0;
        tbl[11].exp_done = 1'b1;
        tbl[12].exp_rd_en = 1'b1;
        tbl[13].exp_rd_en = 1'b1;
        tbl[13].exp_addr  = 3'd4;
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].start, tbl[i].ready);
            check($sformatf("vec%0d_valid", i), valid_a, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                check($sformatf("vec%0d_data", i), data_a, tbl[i].exp_data);
                check($sformatf("vec%0d_last", i), last_a, tbl[i].exp_last);
            end
            check($sformatf("vec%0d_done", i), done_a, tbl[i].exp_done);
            check($sformatf("vec%0d_busy", i), busy_a, tbl[i].exp_busy);
            check($sformatf("vec%0d_rd_en", i), rd_en_a, tbl[i].exp_rd_en);
            check($sformatf("vec%0d_addr", i), addr_a, tbl[i].exp_addr);
        end
        do_reset();

        // Randomised RAM contents under the various backpressure patterns.
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 8; i++) ram_a[i] = $urandom();
            case (f)
                0:       run_frame(1'b0, 0, 1'b0, -1);
                1:       run_frame(1'b0, 1, 1'b0, -1);
                2:       run_frame(1'b0, 3, 1'b0, -1);
                3:       run_frame(1'b0, 0, 1'b1, -1);
                default: run_frame(1'b0, 2, 1'b0, -1);
            endcase
        end

        // Reset while word 3 is presented: aborts silently, then a clean frame.
        run_frame(1'b0, 0, 1'b0, 3);
        @(negedge clk);
        #1;
        check("abort_busy",  busy_a, 1'b0);
        check("abort_done",  done_a, 1'b0);
        check("abort_valid", valid_a, 1'b0);
        check("abort_rd_en", rd_en_a, 1'b0);
        check("abort_data",  data_a, '0);
        check("abort_last",  last_a, 1'b0);
        check("abort_addr",  addr_a, 3'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1);
            check("abort_no_done", done_a, 1'b0);
        end
        run_frame(1'b0, 0, 1'b0, -1);

        // N=256 natural order, RAM[a]=~a, then random data with random ready.
        run_frame(1'b1, 0, 1'b0, -1);
        for (int i = 0; i < 256; i++) ram_b[i] = $urandom();
        run_frame(1'b1, 2, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
